exec_ctrl_unit: RTL and testbench

EXEC_CTRL_UNIT -- requirements
Module: exec_ctrl_unit

---
 rtl/exec_ctrl_pkg.sv | 16 +
 rtl/exec_ctrl_unit_rise_edge_det.sv | 22 ++
 rtl/exec_ctrl_unit.sv | 198 +++++++++++++++++++
 tb/tb_exec_ctrl_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared types and default parameters for the execution control unit.
// The optional EXEC_CTRL_SAT_CNT_EN build macro is consumed by exec_ctrl_unit.
package exec_ctrl_pkg;

  localparam int DEF_NUM_IN  = 4;
  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_CNT_W   = 32;

  // Encoding 2'd3 is never entered and is decoded as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_EXEC   = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/exec_ctrl_unit_rise_edge_det.sv
// Rising-edge detector: one history register plus AND-NOT, asynchronous active-low reset.
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic prev_r;

  // History register holding the previous-cycle level of sig.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= sig;
    end
  end

  assign rise = sig & ~prev_r;

endmodule

// File: rtl/exec_ctrl_unit.sv
// Execution control FSM: CSR edge detection, start pulses and performance counters.
// Build macro EXEC_CTRL_SAT_CNT_EN makes the counters saturate instead of wrapping.
module exec_ctrl_unit
  import exec_ctrl_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_configuration_i,
  input  logic               start_execution_i,
  input  logic               clear_counters_i,
  input  logic [NUM_IN-1:0]  in_chan_en_i,
  input  logic [NUM_OUT-1:0] out_chan_en_i,
  input  logic               data_config_done_i,
  input  logic [NUM_OUT-1:0] data_output_done_i,
  input  logic [NUM_IN-1:0]  data_read_stall_i,
  input  logic [NUM_OUT-1:0] data_write_stall_i,
  output logic               execute_config_o,
  output logic [NUM_IN-1:0]  execute_input_o,
  output logic [NUM_OUT-1:0] execute_output_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   cycle_count_load_config_o,
  output logic [CNT_W-1:0]   cycle_count_execute_o,
  output logic [CNT_W-1:0]   cycle_count_stall_o
);

  ctrl_state_e        state_r;
  ctrl_state_e        state_nxt_s;
  logic               load_rise_s;
  logic               start_rise_s;
  logic               armed_r;
  logic               load_edge_s;
  logic               start_edge_s;
  logic               cfg_go_s;
  logic               exec_go_s;
  logic               exec_fin_s;
  logic               all_done_s;
  logic               stall_any_s;
  logic [NUM_OUT-1:0] out_mask_r;
  logic               done_r;
  logic [CNT_W-1:0]   cnt_cfg_r;
  logic [CNT_W-1:0]   cnt_exec_r;
  logic [CNT_W-1:0]   cnt_stall_r;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
`ifdef EXEC_CTRL_SAT_CNT_EN
    if (&cnt) begin
      return cnt;
    end else begin
      return cnt + CNT_W'(1);
    end
`else
    return cnt + CNT_W'(1);
`endif
  endfunction

  rise_edge_det u_load_det (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .sig   (load_configuration_i),
    .rise  (load_rise_s)
  );

  rise_edge_det u_start_det (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .sig   (start_execution_i),
    .rise  (start_rise_s)
  );

  // The edge registers are still 0 right after reset, so a CSR level held
  // through reset would look like an edge; suppress edges until one clock has
  // captured the real level. This also keeps pulses low while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= 1'b1;
    end
  end

  assign load_edge_s  = load_rise_s & armed_r;
  assign start_edge_s = start_rise_s & armed_r;
  assign all_done_s   = &(data_output_done_i | ~out_mask_r);
  assign stall_any_s  = (|(data_read_stall_i & in_chan_en_i)) |
                        (|(data_write_stall_i & out_mask_r));

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and transition strobes; edges outside IDLE are dropped.
  always_comb begin
    state_nxt_s = state_r;
    cfg_go_s    = 1'b0;
    exec_go_s   = 1'b0;
    exec_fin_s  = 1'b0;
    case (state_r)
      ST_CONFIG: begin
        if (data_config_done_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CONFIG;
        end
      end
      ST_EXEC: begin
        if (all_done_s) begin
          state_nxt_s = ST_IDLE;
          exec_fin_s  = 1'b1;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      default: begin
        if (load_edge_s) begin
          state_nxt_s = ST_CONFIG;
          cfg_go_s    = 1'b1;
        end else if (start_edge_s && (out_chan_en_i != '0)) begin
          state_nxt_s = ST_EXEC;
          exec_go_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
    endcase
  end

  // FSM outputs: same-cycle start pulses and status decode.
  always_comb begin
    execute_config_o = cfg_go_s;
    if (exec_go_s) begin
      execute_input_o  = in_chan_en_i;
      execute_output_o = out_chan_en_i;
    end else begin
      execute_input_o  = '0;
      execute_output_o = '0;
    end
    busy_o  = (state_r == ST_CONFIG) || (state_r == ST_EXEC);
    state_o = state_r;
  end

  // Output-channel mask latched at start and done flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_mask_r <= '0;
      done_r     <= 1'b0;
    end else if (exec_go_s) begin
      out_mask_r <= out_chan_en_i;
      done_r     <= 1'b0;
    end else if (exec_fin_s) begin
      done_r     <= 1'b1;
    end
  end

  // Performance counters; clear overrides load and increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_cfg_r   <= '0;
      cnt_exec_r  <= '0;
      cnt_stall_r <= '0;
    end else if (clear_counters_i) begin
      cnt_cfg_r   <= '0;
      cnt_exec_r  <= '0;
      cnt_stall_r <= '0;
    end else begin
      if (cfg_go_s) begin
        cnt_cfg_r <= '0;
      end else if (state_r == ST_CONFIG) begin
        cnt_cfg_r <= cnt_inc(cnt_cfg_r);
      end
      if (exec_go_s) begin
        cnt_exec_r  <= '0;
        cnt_stall_r <= '0;
      end else if (state_r == ST_EXEC) begin
        cnt_exec_r <= cnt_inc(cnt_exec_r);
        if (stall_any_s) begin
          cnt_stall_r <= cnt_inc(cnt_stall_r);
        end
      end
    end
  end

  assign done_o                    = done_r;
  assign cycle_count_load_config_o = cnt_cfg_r;
  assign cycle_count_execute_o     = cnt_exec_r;
  assign cycle_count_stall_o       = cnt_stall_r;

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Directed self-checking bench for exec_ctrl_unit (CNT_W=8; honours EXEC_CTRL_SAT_CNT_EN).
module tb_exec_ctrl_unit;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load, start, clr;
  logic [NI-1:0] in_en, rd_stall;
  logic [NO-1:0] out_en, out_done, wr_stall;
  logic          cfg_done;
  logic          ex_cfg;
  logic [NI-1:0] ex_in;
  logic [NO-1:0] ex_out;
  logic          busy, done;
  logic [1:0]    state;
  logic [CW-1:0] cnt_cfg, cnt_exec, cnt_stall;

  int checks = 0;
  int failures = 0;
  int cfg_pulses = 0;
  int exec_pulses = 0;

  exec_ctrl_unit #(.NUM_IN(NI), .NUM_OUT(NO), .CNT_W(CW)) dut (
    .clk_i                     (clk),
    .rst_ni                    (rst_n),
    .load_configuration_i      (load),
    .start_execution_i         (start),
    .clear_counters_i          (clr),
    .in_chan_en_i              (in_en),
    .out_chan_en_i             (out_en),
    .data_config_done_i        (cfg_done),
    .data_output_done_i        (out_done),
    .data_read_stall_i         (rd_stall),
    .data_write_stall_i        (wr_stall),
    .execute_config_o          (ex_cfg),
    .execute_input_o           (ex_in),
    .execute_output_o          (ex_out),
    .busy_o                    (busy),
    .done_o                    (done),
    .state_o                   (state),
    .cycle_count_load_config_o (cnt_cfg),
    .cycle_count_execute_o     (cnt_exec),
    .cycle_count_stall_o       (cnt_stall)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cfg_pulses  <= cfg_pulses + int'(ex_cfg);
    exec_pulses <= exec_pulses + int'(|ex_out);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; start = 1'b1; clr = 1'b0;
    in_en = 4'b0011; out_en = 4'b0101; cfg_done = 1'b0;
    out_done = 4'b0000; rd_stall = 4'b0000; wr_stall = 4'b0000;
    #2;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pulse_out", 64'(ex_out), 64'd0);
    chk("rst_cnt", 64'({cnt_cfg, cnt_exec, cnt_stall}), 64'd0);
    step(); start = 1'b0;
    step(); rst_n = 1'b1;
    step(); step();

    // Configuration: edge, then done on the 6th CONFIG cycle.
    load = 1'b1; #1;
    chk("cfg_pulse", 64'(ex_cfg), 64'd1);
    chk("cfg_edge_state", 64'(state), 64'd0);
    step(); load = 1'b0; #1;
    chk("cfg_state", 64'(state), 64'd1);
    chk("cfg_pulse_once", 64'(ex_cfg), 64'd0);
    chk("cfg_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 5; i++) step();
    cfg_done = 1'b1;
    step(); cfg_done = 1'b0; #1;
    chk("cfg_count", 64'(cnt_cfg), 64'd6);
    chk("cfg_back_idle", 64'(state), 64'd0);
    chk("cfg_pulses", 64'(cfg_pulses), 64'd1);

    // Simultaneous load and start: configuration wins, start in CONFIG ignored.
    load = 1'b1; start = 1'b1; #1;
    chk("both_cfg_pulse", 64'(ex_cfg), 64'd1);
    chk("both_no_out", 64'(ex_out), 64'd0);
    chk("both_no_in", 64'(ex_in), 64'd0);
    step(); start = 1'b0;
    step(); start = 1'b1; #1;
    chk("cfg_start_drop", 64'(ex_out), 64'd0);
    step();
    chk("cfg_stay", 64'(state), 64'd1);
    cfg_done = 1'b1;
    step(); cfg_done = 1'b0; #1;
    chk("cfg2_count", 64'(cnt_cfg), 64'd3);
    step();
    chk("no_queued_start", 64'(state), 64'd0);
    load = 1'b0; start = 1'b0;
    step();

    // Start with empty output mask does nothing.
    out_en = 4'b0000; start = 1'b1; #1;
    chk("empty_mask_in", 64'(ex_in), 64'd0);
    step(); start = 1'b0; #1;
    chk("empty_mask_state", 64'(state), 64'd0);
    chk("empty_mask_cnt", 64'(cnt_exec), 64'd0);
    step();

    // Execution: in 0011, out 0101, done bit0 at cycle 3, bit2 at cycle 7.
    out_en = 4'b0101; start = 1'b1; #1;
    chk("exec_in_pulse", 64'(ex_in), 64'd3);
    chk("exec_out_pulse", 64'(ex_out), 64'd5);
    step(); start = 1'b0; out_en = 4'b0000; #1;
    chk("exec_state", 64'(state), 64'd2);
    chk("exec_pulse_once", 64'(ex_out), 64'd0);
    for (int c = 1; c <= 7; c++) begin
      out_done = 4'b0010 | ((c >= 3) ? 4'b0001 : 4'b0000) | ((c >= 7) ? 4'b0100 : 4'b0000);
      #1;
      if (c == 6) chk("exec_wait", 64'(state), 64'd2);
      step();
    end
    out_done = 4'b0000; #1;
    chk("exec_count", 64'(cnt_exec), 64'd7);
    chk("exec_done", 64'(done), 64'd1);
    chk("exec_idle", 64'(state), 64'd0);
    chk("exec_no_stall", 64'(cnt_stall), 64'd0);

    // Stall counting: disabled read ch3 and unlatched write ch1 ignored.
    out_en = 4'b0001; start = 1'b1;
    step(); start = 1'b0; #1;
    chk("done_cleared", 64'(done), 64'd0);
    for (int c = 1; c <= 12; c++) begin
      rd_stall = ((c <= 10) ? 4'b1000 : 4'b0000) | ((c >= 2 && c <= 5) ? 4'b0001 : 4'b0000);
      wr_stall = ((c <= 10) ? 4'b0010 : 4'b0000) | ((c == 11) ? 4'b0001 : 4'b0000);
      out_done = (c == 12) ? 4'b0001 : 4'b0000;
      step();
    end
    rd_stall = 4'b0000; wr_stall = 4'b0000; out_done = 4'b0000; #1;
    chk("stall_count", 64'(cnt_stall), 64'd5);
    chk("stall_exec_count", 64'(cnt_exec), 64'd12);

    // Synchronous counter clear.
    clr = 1'b1;
    step(); clr = 1'b0; #1;
    chk("clear_cnt", 64'({cnt_cfg, cnt_exec, cnt_stall}), 64'd0);

    // Long configuration: 300 cycles in an 8-bit counter.
    load = 1'b1;
    step(); load = 1'b0;
    for (int i = 1; i <= 299; i++) step();
    cfg_done = 1'b1;
    step(); cfg_done = 1'b0; #1;
`ifdef EXEC_CTRL_SAT_CNT_EN
    chk("long_cfg_count", 64'(cnt_cfg), 64'd255);
`else
    chk("long_cfg_count", 64'(cnt_cfg), 64'd44);
`endif

    // Reset in EXEC cycle 2, start held high through and after reset.
    in_en = 4'b0011; out_en = 4'b0101; start = 1'b1;
    step();
    step(); rst_n = 1'b0; #1;
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_flags", 64'({busy, done, ex_cfg}), 64'd0);
    chk("mid_rst_pulses", 64'({ex_in, ex_out}), 64'd0);
    chk("mid_rst_cnt", 64'({cnt_cfg, cnt_exec, cnt_stall}), 64'd0);
    step(); rst_n = 1'b1; #1;
    chk("post_rst_pulse0", 64'(ex_out), 64'd0);
    step();
    chk("post_rst_pulse1", 64'(ex_out), 64'd0);
    step();
    chk("post_rst_state", 64'(state), 64'd0);
    start = 1'b0;
    step();
    chk("total_cfg_pulses", 64'(cfg_pulses), 64'd3);
    chk("total_exec_pulses", 64'(exec_pulses), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
